btb_nway: RTL and testbench
===========================

// Module: btb_nway
// PURPOSE
//  Parametrised N-way set-associative branch target buffer with per-entry saturating direction counters.
//  Sits in fetch: predicts target and direction for the current PC.
//  Trained by an explicit update port driven from the branch-resolve stage.
//  Replaces the implicit "last missed" training with true per-way LRU and a reset-time invalidation sweep.
// PARAMETERS
//  SET_BITS   10  log2(number of sets); index = PC[SET_BITS+1:2]
//  WAYS       2   associativity, 1/2/4/8; LRU age width AW = max(1,clog2(WAYS))
//  CTR_BITS   2   direction counter width; predict taken when counter MSB = 1
//  TAG_BITS   = 30-SET_BITS (localparam); tag = PC[31:SET_BITS+2]
// PORTS
//  CLK            in   1   clock, all state on posedge
//  RESET          in   1   synchronous, active-high
//  STALL          in   1   fetch stall; suppresses lookup only
//  Lookup_IN      in   1   current fetch instruction is a branch/jump (decoded externally)
//  PC_IN          in   32  current fetch PC
//  Ready_OUT      out  1   1 once invalidation sweep done
//  Valid_OUT      out  1   registered: lookup hit
//  Taken_OUT      out  1   registered: hit entry predicts taken
//  Addr_OUT       out  32  registered: predicted target, 0 when Valid_OUT=0
//  Upd_Valid_IN   in   1   resolved branch update strobe
//  Upd_PC_IN      in   32  PC of resolved branch
//  Upd_Target_IN  in   32  resolved target
//  Upd_Taken_IN   in   1   resolved direction
// BEHAVIOUR
//  Entry = {valid, tag, target[31:0], ctr[CTR_BITS-1:0], age[AW-1:0]}.
//  FSM SWEEP -> RUN:
//   - RESET=1 (any cycle, incl. mid-sweep): enter SWEEP, set counter=0, outputs 0, Ready_OUT=0.
//   - SWEEP: one set per cycle: valid=0, way w age=w, ctr=0; after set 2^SET_BITS-1 go RUN next cycle.
//   - Ready_OUT=1 in RUN only. Lookups/updates ignored in SWEEP; outputs held 0.
//  Lookup (RUN, Lookup_IN=1, STALL=0): 1-cycle latency; outputs next edge.
//   - hit = any way valid with matching tag (at most one; lowest index wins if corrupted).
//   - hit: Valid_OUT=1, Addr_OUT=target, Taken_OUT=ctr MSB; touch LRU of hit way.
//   - miss: Valid_OUT=0, Taken_OUT=0, Addr_OUT=0; no allocation from lookup.
//  Lookup_IN=0 or STALL=1: outputs 0 next edge, no LRU change.
//  Update (RUN, Upd_Valid_IN=1, independent of STALL), applied at the edge:
//   - tag hit: target <= Upd_Target_IN; ctr saturating +1 if taken else -1 (clamp 0 / 2^CTR_BITS-1); touch LRU.
//   - miss & taken: allocate lowest-index invalid way, else way with age=WAYS-1;
//     write valid=1, tag, target, ctr=2^(CTR_BITS-1) (weakly taken); touch LRU.
//   - miss & not taken: no change.
//  LRU touch of way h: age[h]<=0; every way with age < old age[h] increments; others unchanged. Ages always a permutation of 0..WAYS-1.
//  WAYS=1: age field constant 0; allocation always way 0.
//  Same-cycle lookup and update:
//   - lookup reads pre-update array (read-before-write).
//   - same set: only the update's LRU touch applies.
//   - different sets: both apply.
//  No update bypass to lookup; a just-written entry is visible from the next cycle.
// TESTING
//  1) RESET 1 cycle, SET_BITS=4 -> Ready_OUT=0 for 16 cycles after RESET drops, 1 on 17th; lookups during sweep give Valid_OUT=0.
//  2) Update PC=0x00400010 tgt=0x00400100 taken; then lookup 0x00400010 -> next edge Valid=1, Taken=1, Addr=0x00400100.
//  3) WAYS=2: allocate 3 taken branches mapping to set 4 (tags A,B,C), lookup A between B and C -> B evicted, A and C hit.
//  4) Counter: 3x not-taken updates on an entry at 2'b10 -> ctr 0, Taken_OUT=0, Valid=1; 5x taken -> saturates at 3.
//  5) Not-taken update on absent PC 0x00400020 -> subsequent lookup Valid=0 (no allocation).
//  6) Same-cycle update (new target 0x500) and lookup to same entry -> old target out; next lookup gives 0x500.
//  7) RESET mid-sweep and while STALL=1 -> sweep restarts, all prior entries miss.

Source files
------------

// File: rtl/btb_nway.sv
// btb_nway: N-way set-associative branch target buffer with LRU and reset-time invalidation sweep
module btb_nway #(
  parameter int SET_BITS = 10,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        Lookup_IN,
  input  logic [31:0] PC_IN,
  output logic        Ready_OUT,
  output logic        Valid_OUT,
  output logic        Taken_OUT,
  output logic [31:0] Addr_OUT,
  input  logic        Upd_Valid_IN,
  input  logic [31:0] Upd_PC_IN,
  input  logic [31:0] Upd_Target_IN,
  input  logic        Upd_Taken_IN
);
  localparam int AW       = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int TAG_BITS = 30 - SET_BITS;
  localparam int SETS     = 1 << SET_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [AW-1:0]       AGE_OLD  = AW'(WAYS - 1);
  typedef enum logic {SWEEP, RUN} state_t;
  state_t state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                v_q, v_d, t_q, t_d;
  logic [31:0]         a_q, a_d;
  logic [WAYS-1:0]     val_q [SETS];
  logic [TAG_BITS-1:0] tag_q [SETS][WAYS];
  logic [31:0]         tgt_q [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q [SETS][WAYS];
  logic [AW-1:0]       age_q [SETS][WAYS];
  logic [SET_BITS-1:0] lk_set, up_set;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                run, lk_en, lk_hit, up_hit, up_we, lk_touch;
  logic [AW-1:0]       lk_way, up_hw, vic_way, up_way;
  logic [CTR_BITS-1:0] up_c, up_ctr;
  logic [AW-1:0]       lk_age [WAYS];
  logic [AW-1:0]       up_age [WAYS];
  logic                unused_ok;
  assign unused_ok = ^{PC_IN[1:0], Upd_PC_IN[1:0]};
  assign lk_set = PC_IN[SET_BITS+1:2];
  assign lk_tag = PC_IN[31:SET_BITS+2];
  assign up_set = Upd_PC_IN[SET_BITS+1:2];
  assign up_tag = Upd_PC_IN[31:SET_BITS+2];
  assign run    = state_q == RUN && !RESET;
  assign Ready_OUT = state_q == RUN;
  assign Valid_OUT = v_q;
  assign Taken_OUT = t_q;
  assign Addr_OUT  = a_q;
  // Descending scans leave the lowest matching index as the final winner.
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    up_hit  = 1'b0;
    up_hw   = '0;
    vic_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (val_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = AW'(w);
      end
      if (val_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
        up_hit = 1'b1;
        up_hw  = AW'(w);
      end
      if (age_q[up_set][w] == AGE_OLD) vic_way = AW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!val_q[up_set][w]) vic_way = AW'(w);
    up_way = up_hit ? up_hw : vic_way;
    up_c   = ctr_q[up_set][up_hw];
    up_ctr = !up_hit ? CTR_INIT :
             Upd_Taken_IN ? (up_c == CTR_MAX ? CTR_MAX : up_c + 1'b1) :
             (up_c == '0 ? '0 : up_c - 1'b1);
    for (int w = 0; w < WAYS; w++) begin
      lk_age[w] = AW'(w) == lk_way ? '0 :
                  age_q[lk_set][w] < age_q[lk_set][lk_way] ? age_q[lk_set][w] + 1'b1 : age_q[lk_set][w];
      up_age[w] = AW'(w) == up_way ? '0 :
                  age_q[up_set][w] < age_q[up_set][up_way] ? age_q[up_set][w] + 1'b1 : age_q[up_set][w];
    end
  end
  assign lk_en    = run && Lookup_IN && !STALL;
  assign up_we    = run && Upd_Valid_IN && (up_hit || Upd_Taken_IN);
  assign lk_touch = lk_en && lk_hit && !(up_we && up_set == lk_set);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == SET_BITS'(SETS - 1)) state_d = RUN;
    end
    v_d = lk_en && lk_hit;
    t_d = v_d && ctr_q[lk_set][lk_way][CTR_BITS-1];
    a_d = v_d ? tgt_q[lk_set][lk_way] : '0;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      v_q     <= 1'b0;
      t_q     <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      t_q     <= t_d;
      a_q     <= a_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (state_q == SWEEP && !RESET) begin
      val_q[cnt_q] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        ctr_q[cnt_q][w] <= '0;
        age_q[cnt_q][w] <= AW'(w);
      end
    end else begin
      if (up_we) begin
        val_q[up_set][up_way] <= 1'b1;
        tag_q[up_set][up_way] <= up_tag;
        tgt_q[up_set][up_way] <= Upd_Target_IN;
        ctr_q[up_set][up_way] <= up_ctr;
        for (int w = 0; w < WAYS; w++) age_q[up_set][w] <= up_age[w];
      end
      if (lk_touch)
        for (int w = 0; w < WAYS; w++) age_q[lk_set][w] <= lk_age[w];
    end
  end
endmodule

// File: tb/tb_btb_nway.sv
// tb_btb_nway: directed scoreboard bench for btb_nway (SET_BITS=4, WAYS=2, CTR_BITS=2)
module tb_btb_nway;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1, STALL = 1'b0, Lookup_IN = 1'b0;
  logic [31:0] PC_IN = '0;
  logic        Ready_OUT, Valid_OUT, Taken_OUT;
  logic [31:0] Addr_OUT;
  logic        Upd_Valid_IN = 1'b0, Upd_Taken_IN = 1'b0;
  logic [31:0] Upd_PC_IN = '0, Upd_Target_IN = '0;
  int checks = 0, errors = 0;
  logic [33:0] exp_q [$];
  string       name_q [$];
  logic        pend;
  localparam logic [31:0] PA = 32'h0040_0010, PB = 32'h0040_0050, PC_ = 32'h0040_0090;
  localparam logic [31:0] PD = 32'h0040_0030, PE = 32'h0040_0020;
  localparam logic [31:0] TA = 32'h0040_0100, TB = 32'h0040_0200, TC = 32'h0040_0300;
  btb_nway #(.SET_BITS(4), .WAYS(2), .CTR_BITS(2)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .Lookup_IN(Lookup_IN), .PC_IN(PC_IN),
    .Ready_OUT(Ready_OUT), .Valid_OUT(Valid_OUT), .Taken_OUT(Taken_OUT), .Addr_OUT(Addr_OUT),
    .Upd_Valid_IN(Upd_Valid_IN), .Upd_PC_IN(Upd_PC_IN), .Upd_Target_IN(Upd_Target_IN),
    .Upd_Taken_IN(Upd_Taken_IN));
  always #5 CLK = ~CLK;
  task automatic check(input string n, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got v=%b t=%b a=%h, expected v=%b t=%b a=%h",
               n, got[33], got[32], got[31:0], want[33], want[32], want[31:0]);
    end
  endtask
  always @(posedge CLK) begin
    pend = Lookup_IN && !STALL && !RESET;
    @(negedge CLK);
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: lookup result with no expectation queued");
      end else check(name_q.pop_front(), {Valid_OUT, Taken_OUT, Addr_OUT}, exp_q.pop_front());
    end else check("idle_zero", {Valid_OUT, Taken_OUT, Addr_OUT}, '0);
  end
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic expect_lk(input string n, input logic v, input logic t, input logic [31:0] a);
    exp_q.push_back({v, t, a});
    name_q.push_back(n);
  endtask
  task automatic lookup(input string n, input logic [31:0] pc, input logic v, input logic t, input logic [31:0] a);
    PC_IN = pc;
    Lookup_IN = 1'b1;
    expect_lk(n, v, t, a);
    cyc();
    Lookup_IN = 1'b0;
  endtask
  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    Upd_Valid_IN = 1'b1;
    Upd_PC_IN = pc;
    Upd_Target_IN = tgt;
    Upd_Taken_IN = tk;
    cyc();
    Upd_Valid_IN = 1'b0;
  endtask
  // Called right after the last reset edge with RESET already low.
  task automatic sweep_check(input string n, input logic probe);
    PC_IN = PA;
    Lookup_IN = probe;
    for (int i = 0; i < 16; i++) begin
      check({n, "_ready_low"}, {33'b0, Ready_OUT}, 34'd0);
      if (probe) expect_lk({n, "_sweep_lookup"}, 1'b0, 1'b0, 32'h0);
      cyc();
    end
    Lookup_IN = 1'b0;
    check({n, "_ready_high"}, {33'b0, Ready_OUT}, 34'd1);
  endtask
  initial begin
    cyc();
    RESET = 1'b0;
    sweep_check("reset", 1'b1);
    update(PA, TA, 1'b1);
    lookup("alloc_A", PA, 1'b1, 1'b1, TA);
    update(PB, TB, 1'b1);
    lookup("A_between", PA, 1'b1, 1'b1, TA);
    update(PC_, TC, 1'b1);
    lookup("B_evicted", PB, 1'b0, 1'b0, 32'h0);
    lookup("A_kept", PA, 1'b1, 1'b1, TA);
    lookup("C_hit", PC_, 1'b1, 1'b1, TC);
    repeat (3) update(PA, TA, 1'b0);
    lookup("ctr_zero", PA, 1'b1, 1'b0, TA);
    repeat (5) update(PA, TA, 1'b1);
    lookup("ctr_sat", PA, 1'b1, 1'b1, TA);
    repeat (2) update(PA, TA, 1'b0);
    lookup("ctr_after_sat", PA, 1'b1, 1'b0, TA);
    update(PE, 32'h0000_0700, 1'b0);
    lookup("nt_no_alloc", PE, 1'b0, 1'b0, 32'h0);
    Upd_Valid_IN = 1'b1;
    Upd_PC_IN = PC_;
    Upd_Target_IN = 32'h0000_0500;
    Upd_Taken_IN = 1'b1;
    lookup("same_cycle_old", PC_, 1'b1, 1'b1, TC);
    Upd_Valid_IN = 1'b0;
    lookup("same_cycle_new", PC_, 1'b1, 1'b1, 32'h0000_0500);
    STALL = 1'b1;
    Lookup_IN = 1'b1;
    PC_IN = PA;
    Upd_Valid_IN = 1'b1;
    Upd_PC_IN = PD;
    Upd_Target_IN = 32'h0000_0600;
    Upd_Taken_IN = 1'b1;
    cyc();
    Upd_Valid_IN = 1'b0;
    Lookup_IN = 1'b0;
    STALL = 1'b0;
    lookup("upd_in_stall", PD, 1'b1, 1'b1, 32'h0000_0600);
    STALL = 1'b1;
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    repeat (5) cyc();
    check("mid_sweep_ready", {33'b0, Ready_OUT}, 34'd0);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    STALL = 1'b0;
    sweep_check("restart", 1'b0);
    lookup("post_reset_A", PA, 1'b0, 1'b0, 32'h0);
    lookup("post_reset_C", PC_, 1'b0, 1'b0, 32'h0);
    lookup("post_reset_D", PD, 1'b0, 1'b0, 32'h0);
    repeat (2) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
